vga_frame_scanner: RTL and testbench
====================================

// Module: vga_frame_scanner
// PURPOSE
//   Parametrised VGA raster generator with BRAM pixel fetch. Divides clk into a
//   pixel tick, scans a configurable H/V timing, issues one BRAM read per active
//   pixel and returns sync/DE/RGB aligned to the returned data. Sits between the
//   frame-buffer BRAM and the VGA pins; generalises the fixed-640x480 VGA block
//   with configurable timing, sync polarity, pixel width and BRAM read latency.
// PARAMETERS
//   CLK_DIV_VAL   4    clk cycles per pixel tick (>=1; 1 = tick every cycle)
//   H_ACTIVE      640  active pixels per line
//   H_FP          16   horizontal front porch, pixels
//   H_SYNC        96   hsync width, pixels
//   H_BP          48   horizontal back porch, pixels
//   V_ACTIVE      480  active lines per frame
//   V_FP          10   vertical front porch, lines
//   V_SYNC        2    vsync width, lines
//   V_BP          33   vertical back porch, lines
//   HSYNC_POL     0    asserted level of hsync (0 = active-low)
//   VSYNC_POL     0    asserted level of vsync
//   PIX_W         12   pixel/RGB width, bits
//   BRAM_RD_LAT   1    BRAM read latency, clk edges (>=1)
//   BYTES_PER_PIX 4    bram_addr step per pixel
// PORTS
//   clk          in   1      system clock, rising edge
//   reset        in   1      asynchronous reset, active-high
//   enable       in   1      1 = scan; 0 = hold idle and flush
//   bram_din     in   PIX_W  BRAM read data
//   bram_addr    out  32     BRAM byte address
//   bram_en      out  1      BRAM read enable, one clk per active pixel
//   hsync        out  1      horizontal sync
//   vsync        out  1      vertical sync
//   de           out  1      display enable, aligned with rgb
//   rgb          out  PIX_W  pixel out; 0 when de=0
//   frame_start  out  1      1-clk pulse aligned with output of pixel (0,0)
// BEHAVIOUR
//   Reset (async, immediate): div/h/v counters 0, delay line cleared,
//     hsync=~HSYNC_POL, vsync=~VSYNC_POL, de=0, rgb=0, bram_en=0, bram_addr=0,
//     frame_start=0. Release mid-line restarts at (h,v)=(0,0).
//   Tick: div counts 0..CLK_DIV_VAL-1; tick=1 when div==CLK_DIV_VAL-1.
//   Counters hold the NEXT pixel (h,v). H_TOTAL=sum(H_*), V_TOTAL=sum(V_*).
//     On tick edge E: h wraps H_TOTAL-1->0 with v+1; v wraps V_TOTAL-1->0.
//   Regions: active h<H_ACTIVE && v<V_ACTIVE; hsync asserted for
//     H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync likewise on v.
//   Fetch at tick edge E for current (h,v): bram_en<=active for exactly one clk,
//     bram_addr<=(v*H_ACTIVE+h)*BYTES_PER_PIX (32-bit; held when bram_en=0);
//     sync/de/first-pixel flags enter a delay line of BRAM_RD_LAT stages.
//   Output at edge E+1+BRAM_RD_LAT: hsync, vsync, de, frame_start update
//     together; rgb<=bram_din if de else 0. Outputs hold between ticks;
//     frame_start is one clk only.
//   enable=0: synchronously clears div/counters/delay line, outputs to reset
//     values. enable 0->1: first tick after CLK_DIV_VAL clks fetches (0,0).
//   Simultaneous h and v wrap: both in same edge; address returns to 0.
// TESTING
//   Defaults, 2 frames -> hsync period 3200 clk, low 384 clk; vsync period
//     1,680,000 clk, low 6400 clk; frame_start once per frame.
//   Defaults, BRAM model lat 1 returning addr[13:2] -> 307200 bram_en/frame,
//     addr 0,4,..,1228796 then 0; rgb==expected when de, 0 otherwise.
//   H 4/1/1/1, V 2/1/1/1, CLK_DIV_VAL=1, BRAM_RD_LAT=2 -> bram_en high 4
//     consecutive clk per active line; de rises 3 clk after bram_en, stays 4.
//   HSYNC_POL=1, VSYNC_POL=1 -> sync idle 0, asserted 1; widths unchanged.
//   reset pulse mid-line, no clk edge -> all outputs at reset values at once;
//     after release first bram_addr=0 and frame_start precedes any other de.
//   enable low for 10 clk mid-frame -> outputs idle; re-enable restarts at (0,0).

Source files
------------

// File: rtl/vga_frame_scanner.sv
// VGA raster generator: divides clk into a pixel tick, scans configurable H/V timing,
// fetches one BRAM word per active pixel and emits sync/DE/RGB aligned to the returned data.
module vga_frame_scanner #(
  parameter int CLK_DIV_VAL   = 4,
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int HSYNC_POL     = 0,
  parameter int VSYNC_POL     = 0,
  parameter int PIX_W         = 12,
  parameter int BRAM_RD_LAT   = 1,
  parameter int BYTES_PER_PIX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [PIX_W-1:0] bram_din,
  output logic [31:0]      bram_addr,
  output logic             bram_en,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [PIX_W-1:0] rgb,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int DIV_W   = (CLK_DIV_VAL > 1) ? $clog2(CLK_DIV_VAL) : 1;

  localparam logic [HW-1:0]    H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]    V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV_VAL - 1);
  localparam logic [31:0] HA_32  = 32'(H_ACTIVE);
  localparam logic [31:0] VA_32  = 32'(V_ACTIVE);
  localparam logic [31:0] HS_B   = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_E   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_B   = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_E   = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0] BPP_32 = 32'(BYTES_PER_PIX);
  localparam logic        HS_ON  = 1'(HSYNC_POL);
  localparam logic        VS_ON  = 1'(VSYNC_POL);

  logic [DIV_W-1:0] r_div;
  logic [HW-1:0]    r_h;
  logic [VW-1:0]    r_v;
  // Delay-line word: {vld, hsync_asserted, vsync_asserted, active, first_pixel}
  logic [4:0]       r_dly_p [0:BRAM_RD_LAT];

  logic        w_tick, w_active, w_hs_act, w_vs_act, w_first;
  logic [31:0] w_h32, w_v32, w_addr;

  assign w_tick   = (r_div == DIV_LAST);
  assign w_h32    = 32'(r_h);
  assign w_v32    = 32'(r_v);
  assign w_active = (w_h32 < HA_32) && (w_v32 < VA_32);
  assign w_hs_act = (w_h32 >= HS_B) && (w_h32 < HS_E);
  assign w_vs_act = (w_v32 >= VS_B) && (w_v32 < VS_E);
  assign w_first  = (r_h == '0) && (r_v == '0);
  assign w_addr   = (w_v32 * HA_32 + w_h32) * BPP_32;

  always_ff @(posedge clk or posedge reset) begin
    if (reset || !enable) begin
      r_div       <= '0;
      r_h         <= '0;
      r_v         <= '0;
      for (int i = 0; i <= BRAM_RD_LAT; i++) r_dly_p[i] <= '0;
      bram_en     <= 1'b0;
      bram_addr   <= '0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      de          <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else begin
      r_div      <= w_tick ? '0 : r_div + 1'b1;
      bram_en    <= 1'b0;
      r_dly_p[0] <= '0;
      // Fetch stage: issue the read for the current pixel, then advance to the next one
      if (w_tick) begin
        bram_en    <= w_active;
        if (w_active) bram_addr <= w_addr;
        r_dly_p[0] <= {1'b1, w_hs_act, w_vs_act, w_active, w_first};
        if (r_h == H_LAST) begin
          r_h <= '0;
          r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
        end else begin
          r_h <= r_h + 1'b1;
        end
      end
      for (int i = 1; i <= BRAM_RD_LAT; i++) r_dly_p[i] <= r_dly_p[i-1];
      // Output stage: BRAM data is valid here, BRAM_RD_LAT edges after the fetch
      frame_start <= r_dly_p[BRAM_RD_LAT][4] & r_dly_p[BRAM_RD_LAT][0];
      if (r_dly_p[BRAM_RD_LAT][4]) begin
        hsync <= r_dly_p[BRAM_RD_LAT][3] ? HS_ON : ~HS_ON;
        vsync <= r_dly_p[BRAM_RD_LAT][2] ? VS_ON : ~VS_ON;
        de    <= r_dly_p[BRAM_RD_LAT][1];
        rgb   <= r_dly_p[BRAM_RD_LAT][1] ? bram_din : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Bench for vga_frame_scanner on a small raster: a per-tick pixel model pushes expected
// outputs into a queue, popped on the edge they must appear.
module tb_vga_frame_scanner;

  localparam int D  = 2;
  localparam int L  = 2;
  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam logic HP = 1'b0;
  localparam logic VP = 1'b1;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [11:0] bram_din;
  logic [31:0] bram_addr;
  logic        bram_en, hsync, vsync, de, frame_start;
  logic [11:0] rgb;

  vga_frame_scanner #(
    .CLK_DIV_VAL(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(0), .VSYNC_POL(1), .PIX_W(12), .BRAM_RD_LAT(L), .BYTES_PER_PIX(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .bram_din(bram_din),
    .bram_addr(bram_addr), .bram_en(bram_en), .hsync(hsync), .vsync(vsync),
    .de(de), .rgb(rgb), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Two-stage BRAM returning the pixel index (addr[13:2]) as data
  logic [11:0] r_q1, r_q2;
  always_ff @(posedge clk) begin
    if (bram_en) r_q1 <= bram_addr[13:2];
    r_q2 <= r_q1;
  end
  assign bram_din = r_q2;

  typedef struct {
    int          due;
    logic        hs, vs, de, fs;
    logic [11:0] pix;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          errors  = 0;
  int          edges   = 0;
  logic        m_en    = 1'b0;
  logic        exp_hs, exp_vs, exp_de, exp_fs, exp_en;
  logic [11:0] exp_rgb;
  logic [31:0] exp_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, expv);
    end
  endtask

  task automatic idle_model();
    edges = 0;
    q.delete();
    exp_hs = ~HP; exp_vs = ~VP; exp_de = 1'b0; exp_fs = 1'b0;
    exp_en = 1'b0; exp_rgb = '0; exp_addr = '0;
  endtask

  task automatic compare_all(input string pfx);
    chk({pfx, "_hsync"},  32'(hsync),       32'(exp_hs));
    chk({pfx, "_vsync"},  32'(vsync),       32'(exp_vs));
    chk({pfx, "_de"},     32'(de),          32'(exp_de));
    chk({pfx, "_rgb"},    32'(rgb),         32'(exp_rgb));
    chk({pfx, "_fstart"}, 32'(frame_start), 32'(exp_fs));
    chk({pfx, "_bramen"}, 32'(bram_en),     32'(exp_en));
    chk({pfx, "_addr"},   bram_addr,        exp_addr);
  endtask

  task automatic step(input string pfx);
    exp_t e;
    int   n, idx, h, v;
    @(posedge clk);
    #1;
    if (m_en) begin
      exp_fs = 1'b0;
      exp_en = 1'b0;
      edges++;
      if (edges % D == 0) begin
        n     = edges / D;
        idx   = (n - 1) % (HT * VT);
        h     = idx % HT;
        v     = idx / HT;
        e.due = edges + 1 + L;
        e.hs  = (h >= HA + HF) && (h < HA + HF + HS);
        e.vs  = (v >= VA + VF) && (v < VA + VF + VS);
        e.de  = (h < HA) && (v < VA);
        e.fs  = (h == 0) && (v == 0);
        e.pix = 12'(v * HA + h);
        exp_en = e.de;
        if (e.de) exp_addr = 32'((v * HA + h) * 4);
        q.push_back(e);
      end
      if (q.size() > 0 && q[0].due == edges) begin
        e       = q.pop_front();
        exp_hs  = e.hs ? HP : ~HP;
        exp_vs  = e.vs ? VP : ~VP;
        exp_de  = e.de;
        exp_rgb = e.de ? e.pix : 12'd0;
        exp_fs  = e.fs;
      end
    end else begin
      idle_model();
    end
    compare_all(pfx);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    idle_model();
    #2;
    compare_all("rst_init");
    for (int i = 0; i < 3; i++) step("rst_hold");

    reset = 1'b0;
    m_en  = 1'b1;
    idle_model();
    for (int i = 0; i < 3 * HT * VT * D; i++) step("scan");

    for (int i = 0; i < 13; i++) step("pre_rst");
    #2 reset = 1'b1;
    #1;
    idle_model();
    compare_all("async_rst");
    #2 reset = 1'b0;
    for (int i = 0; i < 130; i++) step("post_rst");

    enable = 1'b0;
    m_en   = 1'b0;
    for (int i = 0; i < 10; i++) step("disabled");
    enable = 1'b1;
    m_en   = 1'b1;
    idle_model();
    for (int i = 0; i < 2 * HT * VT * D + 10; i++) step("reenable");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
